// File: rtl/fsm_pkg.sv
// Shared definitions for the target fsm and its driver: state encoding and
// the Moore output rule.
package fsm_pkg;

    typedef enum logic [1:0] {
        S1 = 2'd0,
        S2 = 2'd1,
        S3 = 2'd2,
        S4 = 2'd3
    } state_t;

    localparam logic [7:0] ERR_COUNT_MAX = 8'd255;

    function automatic logic exp_outp(input state_t s);
        return (s == S1) || (s == S2);
    endfunction

endpackage

// File: rtl/fsm_shadow.sv
// Shadow copy of the target fsm.
// It follows the same x1 stimulus and predicts the Moore output every cycle.
module fsm_shadow
    import fsm_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_x1,
    output state_t o_state,
    output logic   o_exp_outp
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S1;
        case (r_state)
            S1: begin
                if (i_x1) begin
                    w_next = S2;
                end else begin
                    w_next = S3;
                end
            end
            S2:      w_next = S4;
            S3:      w_next = S4;
            S4:      w_next = S1;
            default: w_next = S1;
        endcase
    end

    assign o_state    = r_state;
    assign o_exp_outp = exp_outp(r_state);

endmodule

// File: rtl/fsm_driver.sv
// Drives a target fsm through a requested number of laps while checking its
// Moore output against a shadow copy.
module fsm_driver
    import fsm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_path,
    input  logic [7:0]  cmd_laps,
    output logic        x1,
    input  logic        outp,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_count,
    output logic [15:0] lap_count
);

    state_t      w_state;
    logic        w_exp_outp;
    logic        w_accept;
    logic        w_lap_start;
    logic        w_lap_end;
    logic        w_mismatch;

    logic        r_active;
    logic        r_path;
    logic [7:0]  r_laps_left;
    logic        r_in_lap;
    logic        r_done;
    logic        r_err;
    logic [7:0]  r_err_count;
    logic [15:0] r_lap_count;

    fsm_shadow u_shadow (
        .clk        (clk),
        .reset      (reset),
        .i_x1       (x1),
        .o_state    (w_state),
        .o_exp_outp (w_exp_outp)
    );

    assign w_accept    = cmd_valid && !r_active;
    assign w_lap_start = r_active && (r_laps_left != 8'd0) && (w_state == S1);
    assign w_lap_end   = (w_state == S4) && r_in_lap;
    assign w_mismatch  = (outp != w_exp_outp);

    always_comb begin
        x1 = 1'b0;
        if (w_lap_start) begin
            x1 = r_path;
        end else begin
            x1 = 1'b0;
        end
    end

    // Command acceptance and lap bookkeeping; accept and lap end never coincide
    // because a lap in progress implies the block is busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active    <= 1'b0;
            r_path      <= 1'b0;
            r_laps_left <= 8'd0;
            r_in_lap    <= 1'b0;
            r_done      <= 1'b0;
            r_lap_count <= 16'd0;
        end else begin
            r_done <= 1'b0;
            if (w_lap_start) begin
                r_in_lap <= 1'b1;
            end
            if (w_lap_end) begin
                r_in_lap    <= 1'b0;
                r_laps_left <= r_laps_left - 8'd1;
                r_lap_count <= r_lap_count + 16'd1;
                if (r_laps_left == 8'd1) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end else if (w_accept) begin
                r_path      <= cmd_path;
                r_laps_left <= cmd_laps;
                if (cmd_laps == 8'd0) begin
                    r_done <= 1'b1;
                end else begin
                    r_active <= 1'b1;
                end
            end
        end
    end

    // Error state is independent of lap state so both update in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
            if (r_err_count != ERR_COUNT_MAX) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign cmd_ready = !r_active;
    assign done      = r_done;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign lap_count = r_lap_count;

endmodule
